mem_bank4: RTL and testbench

- Four-bank, word-interleaved main-memory model directly downstream of the set-associative cache controller.
- Consumes the controller's mem_addr / mem_rd / mem_wr / write data.
- Returns read data through a fixed-latency pipeline, plus a per-bank busy vector and a combinational stall.
- The controller paces line fills and write-backs from these busy and stall outputs.

---
 rtl/mem_bank4.sv | 94 +++++++++
 tb/tb_mem_bank4.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bank4.sv
// Four-bank word-interleaved memory model with per-bank occupancy and fixed read latency.
// Define MEM_BANK4_ALIGN_CHK_EN to reject odd byte addresses as illegal requests.
module mem_bank4 #(
    parameter int ADDR_W      = 16,
    parameter int DEPTH_W     = 13,
    parameter int BANK_CYCLES = 4,
    parameter int READ_LAT    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr,
    input  logic [15:0]       data_in,
    input  logic              rd,
    input  logic              wr,
    output logic [15:0]       data_out,
    output logic              data_valid,
    output logic [3:0]        busy,
    output logic              stall,
    output logic              err
);

    // Handshake: a request (rd^wr) is taken in the cycle it is presented when
    // stall=0 and err=0; stall=1 means hold and retry, err=1 means it is dropped.
    logic [1:0]         bank;
    logic [DEPTH_W-1:0] idx;
    logic               req_one;
    logic               illegal;
    logic               accept;
    logic [3:0]         cnt [4];
    logic [15:0]        mem [4][2**DEPTH_W];
    logic [READ_LAT-1:0] vld_pipe;
    logic [15:0]        dat_pipe [READ_LAT];

    assign bank    = addr[2:1];
    assign idx     = addr[DEPTH_W+2:3];
    assign req_one = rd ^ wr;

`ifdef MEM_BANK4_ALIGN_CHK_EN
    assign illegal = (rd & wr) | ((rd | wr) & addr[0]);
`else
    logic unused_addr_lsb;
    assign unused_addr_lsb = addr[0];
    assign illegal = rd & wr;
`endif

    assign err    = illegal;
    assign stall  = req_one & busy[bank] & ~illegal;
    assign accept = req_one & ~busy[bank] & ~illegal;

    for (genvar b = 0; b < 4; b++) begin : g_busy
        assign busy[b] = (cnt[b] != 4'd0);
    end

    // A bank accepts only when its counter is zero, so load and decrement never collide.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int b = 0; b < 4; b++) cnt[b] <= 4'd0;
        end else begin
            for (int b = 0; b < 4; b++) begin
                if (accept && bank == 2'(b))
                    cnt[b] <= 4'(BANK_CYCLES - 1);
                else if (cnt[b] != 4'd0)
                    cnt[b] <= cnt[b] - 4'd1;
            end
        end
    end

    // Array is deliberately outside the reset domain so contents survive reset.
    always_ff @(posedge clk) begin
        if (accept && wr)
            mem[bank][idx] <= data_in;
    end

    always_ff @(posedge clk) begin
        if (accept && rd)
            dat_pipe[0] <= mem[bank][idx];
        for (int i = 1; i < READ_LAT; i++)
            dat_pipe[i] <= dat_pipe[i-1];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_pipe <= '0;
        end else begin
            vld_pipe[0] <= accept & rd;
            for (int i = 1; i < READ_LAT; i++)
                vld_pipe[i] <= vld_pipe[i-1];
        end
    end

    assign data_valid = vld_pipe[READ_LAT-1];
    assign data_out   = data_valid ? dat_pipe[READ_LAT-1] : 16'h0000;

endmodule

// File: tb/tb_mem_bank4.sv
// Self-checking bench for mem_bank4: directed scenarios plus random traffic against
// a cycle-stamped reference model (bank free times, word map, expected return queue).
module tb_mem_bank4;

    localparam int BANK_CYCLES = 4;
    localparam int READ_LAT    = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] addr;
    logic [15:0] data_in;
    logic        rd;
    logic        wr;
    logic [15:0] data_out;
    logic        data_valid;
    logic [3:0]  busy;
    logic        stall;
    logic        err;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit mon_en   = 1'b0;

    // reference model
    int          free_at [4];
    logic [15:0] mem_m [int];
    int          due_q [$];
    logic [15:0] exp_q [$];

    mem_bank4 dut (
        .clk        (clk),
        .rst        (rst),
        .addr       (addr),
        .data_in    (data_in),
        .rd         (rd),
        .wr         (wr),
        .data_out   (data_out),
        .data_valid (data_valid),
        .busy       (busy),
        .stall      (stall),
        .err        (err)
    );

    // clock / reset block
    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1);
    end

    task automatic model_flush();
        for (int b = 0; b < 4; b++) free_at[b] = 0;
        due_q.delete();
        exp_q.delete();
    endtask

    // scoreboard: busy and read return checked every cycle, just after the edge
    always @(posedge clk) begin
        #1;
        if (mon_en) begin
            for (int b = 0; b < 4; b++) begin
                n_checks++;
                if (busy[b] !== (cyc < free_at[b])) begin
                    n_fail++;
                    $display("FAIL sb_busy[%0d] cyc=%0d got=%b want=%b", b, cyc, busy[b], (cyc < free_at[b]));
                end
            end
            n_checks++;
            if (due_q.size() > 0 && due_q[0] == cyc) begin
                if (data_valid !== 1'b1 || data_out !== exp_q[0]) begin
                    n_fail++;
                    $display("FAIL sb_read cyc=%0d got valid=%b data=%h want valid=1 data=%h",
                             cyc, data_valid, data_out, exp_q[0]);
                end
                void'(due_q.pop_front());
                void'(exp_q.pop_front());
            end else if (data_valid !== 1'b0 || data_out !== 16'h0000) begin
                n_fail++;
                $display("FAIL sb_idle cyc=%0d got valid=%b data=%h want valid=0 data=0000",
                         cyc, data_valid, data_out);
            end
        end
    end

    // driver: one cycle of request, model updated from the rules, expectations returned
    task automatic drive(input logic r, input logic w, input logic [15:0] a, input logic [15:0] d,
                         output logic e_stall, output logic e_err, output logic acc);
        int b;
        int c;
        @(negedge clk);
        rd = r; wr = w; addr = a; data_in = d;
        c = cyc;
        b = int'(a[2:1]);
        e_err = r & w;
`ifdef MEM_BANK4_ALIGN_CHK_EN
        if ((r | w) && a[0]) e_err = 1'b1;
`endif
        e_stall = !e_err && (r ^ w) && (c < free_at[b]);
        acc     = !e_err && (r ^ w) && !e_stall;
        if (acc) begin
            free_at[b] = c + BANK_CYCLES;
            if (w) mem_m[int'(a[15:1])] = d;
            else begin
                due_q.push_back(c + READ_LAT);
                exp_q.push_back(mem_m[int'(a[15:1])]);
            end
        end
        #1;
    endtask

    task automatic idle(input int n);
        logic s, e, a;
        repeat (n) drive(1'b0, 1'b0, 16'h0000, 16'h0000, s, e, a);
    endtask

    task automatic write_word(input logic [15:0] a, input logic [15:0] d);
        logic s, e, acc;
        int tries = 0;
        do begin
            drive(1'b0, 1'b1, a, d, s, e, acc);
            tries++;
        end while (!acc && tries < 16);
        if (!acc) begin
            n_checks++; n_fail++;
            $display("FAIL write_timeout addr=%h never accepted", a);
        end
    endtask

    task automatic test_reset();
        rd = 1'b0; wr = 1'b0; addr = '0; data_in = '0;
        rst = 1'b1;
        #2 rst = 1'b0;
        #1;
        n_checks++;
        if (busy !== 4'b0000 || data_valid !== 1'b0 || data_out !== 16'h0000 || stall !== 1'b0 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state got busy=%b valid=%b data=%h stall=%b err=%b want 0000/0/0000/0/0",
                     busy, data_valid, data_out, stall, err);
        end
        model_flush();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        mon_en = 1'b1;
    endtask

    task automatic test_write_read();
        logic s, e, acc;
        logic [15:0] a = 16'h0010;
        logic [3:0] exp_b = 4'b0001 << a[2:1];
        drive(1'b0, 1'b1, a, 16'hBEEF, s, e, acc);
        n_checks++;
        if (stall !== 1'b0 || err !== 1'b0) begin
            n_fail++; $display("FAIL wr_accept got stall=%b err=%b want 0/0", stall, err);
        end
        for (int i = 1; i <= 3; i++) begin
            idle(1);
            n_checks++;
            if (busy !== exp_b || stall !== 1'b0) begin
                n_fail++; $display("FAIL wr_busy t0+%0d got busy=%b stall=%b want %b/0", i, busy, stall, exp_b);
            end
        end
        drive(1'b1, 1'b0, a, 16'h0000, s, e, acc);
        n_checks++;
        if (stall !== 1'b0 || busy !== 4'b0000) begin
            n_fail++; $display("FAIL rd_accept t0+4 got stall=%b busy=%b want 0/0000", stall, busy);
        end
        idle(1);
        idle(1);
        n_checks++;
        if (data_valid !== 1'b1 || data_out !== 16'hBEEF) begin
            n_fail++; $display("FAIL rd_return t0+6 got valid=%b data=%h want 1/beef", data_valid, data_out);
        end
    endtask

    task automatic test_back_to_back();
        logic s, e, acc;
        logic [3:0] exp_b;
        for (int k = 0; k < 4; k++) write_word(16'(2 * k), 16'h1111 * 16'(k + 1));
        idle(BANK_CYCLES);
        for (int k = 0; k < 6; k++) begin
            if (k < 4) drive(1'b1, 1'b0, 16'(2 * k), 16'h0000, s, e, acc);
            else idle(1);
            exp_b = 4'b0000;
            for (int j = 0; j < 4; j++)
                if (j < k && k < j + BANK_CYCLES) exp_b[j] = 1'b1;
            n_checks++;
            if (busy !== exp_b || stall !== 1'b0) begin
                n_fail++; $display("FAIL b2b_busy k=%0d got busy=%b stall=%b want %b/0", k, busy, stall, exp_b);
            end
            n_checks++;
            if (k >= READ_LAT) begin
                if (data_valid !== 1'b1 || data_out !== 16'h1111 * 16'(k - READ_LAT + 1)) begin
                    n_fail++; $display("FAIL b2b_data k=%0d got valid=%b data=%h want 1/%h",
                                       k, data_valid, data_out, 16'h1111 * 16'(k - READ_LAT + 1));
                end
            end else if (data_valid !== 1'b0) begin
                n_fail++; $display("FAIL b2b_early k=%0d got valid=%b want 0", k, data_valid);
            end
        end
    endtask

    task automatic test_stall_retry();
        logic s, e, acc;
        logic done = 1'b0;
        int pulses = 0;
        write_word(16'h0008, 16'h5A5A);
        write_word(16'h0000, 16'h0F0F);
        idle(BANK_CYCLES);
        drive(1'b1, 1'b0, 16'h0008, 16'h0000, s, e, acc);
        for (int i = 1; i <= 8; i++) begin
            if (!done) drive(1'b1, 1'b0, 16'h0000, 16'h0000, s, e, acc);
            else idle(1);
            if (data_valid === 1'b1) begin
                pulses++;
                n_checks++;
                if (i != 2 && i != 6) begin
                    n_fail++; $display("FAIL retry_pulse_time got pulse at t0+%0d want t0+2 or t0+6", i);
                end
            end
            if (!done) begin
                n_checks++;
                if (stall !== (i < 4)) begin
                    n_fail++; $display("FAIL retry_stall t0+%0d got stall=%b want %b", i, stall, (i < 4));
                end
                done = (stall === 1'b0);
            end
        end
        n_checks++;
        if (pulses != 2 || !done) begin
            n_fail++; $display("FAIL retry_pulses got pulses=%0d accepted=%b want 2/1", pulses, done);
        end
    endtask

    task automatic test_error();
        logic s, e, acc;
        logic [3:0] bsave;
        write_word(16'h0020, 16'h1357);
        idle(BANK_CYCLES);
        bsave = busy;
        drive(1'b1, 1'b1, 16'h0020, 16'hDEAD, s, e, acc);
        n_checks++;
        if (err !== 1'b1 || stall !== 1'b0) begin
            n_fail++; $display("FAIL err_flag got err=%b stall=%b want 1/0", err, stall);
        end
        idle(1);
        n_checks++;
        if (busy !== bsave) begin
            n_fail++; $display("FAIL err_busy got busy=%b want %b", busy, bsave);
        end
        drive(1'b1, 1'b0, 16'h0022, 16'h0000, s, e, acc);
        drive(1'b1, 1'b1, 16'h0022, 16'hDEAD, s, e, acc);
        n_checks++;
        if (err !== 1'b1 || stall !== 1'b0) begin
            n_fail++; $display("FAIL err_on_busy got err=%b stall=%b want 1/0", err, stall);
        end
        idle(BANK_CYCLES);
        drive(1'b1, 1'b0, 16'h0020, 16'h0000, s, e, acc);
        idle(READ_LAT);
        n_checks++;
        if (data_valid !== 1'b1 || data_out !== 16'h1357) begin
            n_fail++; $display("FAIL err_nowrite got valid=%b data=%h want 1/1357", data_valid, data_out);
        end
    endtask

    task automatic test_reset_mid();
        logic s, e, acc;
        write_word(16'h0002, 16'h1234);
        idle(BANK_CYCLES);
        drive(1'b1, 1'b0, 16'h0002, 16'h0000, s, e, acc);
        idle(1);
        n_checks++;
        if (busy !== 4'b0010) begin
            n_fail++; $display("FAIL rstmid_pre got busy=%b want 0010", busy);
        end
        rst = 1'b0;
        model_flush();
        #1;
        n_checks++;
        if (busy !== 4'b0000 || data_valid !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_clear got busy=%b valid=%b want 0000/0", busy, data_valid);
        end
        idle(1);
        n_checks++;
        if (data_valid !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_drop got valid=%b want 0", data_valid);
        end
        idle(1);
        rst = 1'b1;
        drive(1'b1, 1'b0, 16'h0002, 16'h0000, s, e, acc);
        idle(READ_LAT);
        n_checks++;
        if (data_valid !== 1'b1 || data_out !== 16'h1234) begin
            n_fail++; $display("FAIL rstmid_retain got valid=%b data=%h want 1/1234", data_valid, data_out);
        end
    endtask

    task automatic test_align();
        logic s, e, acc;
        logic [15:0] want;
        int tries;
        idle(BANK_CYCLES);
        drive(1'b1, 1'b0, 16'h0002, 16'h0000, s, e, acc);
        drive(1'b0, 1'b1, 16'h0003, 16'hA5A5, s, e, acc);
`ifdef MEM_BANK4_ALIGN_CHK_EN
        want = 16'h1234;
        n_checks++;
        if (err !== 1'b1 || stall !== 1'b0) begin
            n_fail++; $display("FAIL align_err got err=%b stall=%b want 1/0", err, stall);
        end
`else
        want = 16'hA5A5;
        n_checks++;
        if (err !== 1'b0 || stall !== 1'b1) begin
            n_fail++; $display("FAIL align_stall got err=%b stall=%b want 0/1", err, stall);
        end
        tries = 0;
        while (!acc && tries < 16) begin
            drive(1'b0, 1'b1, 16'h0003, 16'hA5A5, s, e, acc);
            tries++;
        end
`endif
        idle(BANK_CYCLES);
        drive(1'b1, 1'b0, 16'h0002, 16'h0000, s, e, acc);
        idle(READ_LAT);
        n_checks++;
        if (data_valid !== 1'b1 || data_out !== want) begin
            n_fail++; $display("FAIL align_word got valid=%b data=%h want 1/%h", data_valid, data_out, want);
        end
    endtask

    task automatic test_random();
        logic s, e, acc;
        logic r, w;
        logic [15:0] a;
        int op;
        for (int k = 0; k < 32; k++) write_word(16'(2 * k), 16'($urandom));
        idle(BANK_CYCLES);
        for (int n = 0; n < 300; n++) begin
            op = $urandom_range(0, 9);
            r  = (op <= 3) || (op == 7);
            w  = (op >= 4 && op <= 7);
            a  = 16'($urandom_range(0, 63));
            drive(r, w, a, 16'($urandom), s, e, acc);
            n_checks++;
            if (stall !== s || err !== e) begin
                n_fail++; $display("FAIL rand_ctrl n=%0d addr=%h rd=%b wr=%b got stall=%b err=%b want %b/%b",
                                   n, a, r, w, stall, err, s, e);
            end
        end
        idle(BANK_CYCLES + READ_LAT);
        n_checks++;
        if (due_q.size() != 0) begin
            n_fail++; $display("FAIL rand_drain got %0d outstanding returns want 0", due_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_back_to_back();
        test_stall_retry();
        test_error();
        test_reset_mid();
        test_align();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
